pipeline_hazard_ctrl: RTL and testbench
=======================================

# pipeline_hazard_ctrl

Central stall/flush controller for the five-stage ARM pipeline (IF, ID, EX, MEM, WB). It drives the `ld` and `flush` inputs of the PC register, the pipeline registers and the status register. It decides bubbles for data hazards, squashes wrong-path instructions on taken branches, and freezes the whole pipeline while a multi-cycle data-memory access completes.

## Interface
- `MEM_WAIT`, 4, WAIT-state cycles per data-memory access; legal range 1..15.
- `REG_AW`, 4, register-address width.
- `clk`  in  1  clock
- `rst`  in  1  reset, asynchronous, active-high
- `id_src1`, `id_src2`  in  REG_AW  source registers of the instruction in ID
- `id_two_src`  in  1  ID instruction reads `id_src2`
- `ex_dest`, `ex_wb_en`, `ex_mem_rd`  in  REG_AW/1/1  destination, writeback enable and load flag of the instruction in EX
- `mem_dest`, `mem_wb_en`  in  REG_AW/1  destination and writeback enable of the instruction in MEM
- `wb_dest`, `wb_wb_en`  in  REG_AW/1  destination and writeback enable of the instruction in WB
- `ex_src1`, `ex_src2`  in  REG_AW  source registers of the instruction in EX; used only with forwarding
- `mem_req`  in  1  instruction in MEM performs a load or store
- `branch_taken`  in  1  taken branch resolved in EX
- `ex_s_upd`  in  1  EX instruction updates flags
- `pc_ld`, `if_id_ld`, `id_ex_ld`, `ex_mem_ld`, `mem_wb_ld`  out  1  register load enables
- `if_id_flush`, `id_ex_flush`  out  1  flush requests; effective only together with the matching `ld`
- `status_ld`  out  1  status-register load enable
- `fwd_sel1`, `fwd_sel2`  out  2  EX operand select: 00 = register file, 01 = MEM-stage result, 10 = WB result
- `freeze`  out  1  memory freeze active

## Operation
- Memory FSM states:
  - IDLE: if `mem_req`=1, assert `freeze`, load `cnt` = MEM_WAIT-1 and go to WAIT.
  - WAIT: assert `freeze`. If `cnt`==0, go to DONE; otherwise decrement `cnt`.
  - DONE: `freeze`=0 and `mem_req` is ignored; go to IDLE.
- While `freeze`=1, every `ld`, every `flush` and `status_ld` are 0. Nothing else is evaluated.
- Register hazard `hz(s)` for a source `s`:
  - without forwarding: (`ex_wb_en` and `ex_dest`==`s`) or (`mem_wb_en` and `mem_dest`==`s`);
  - with forwarding: see Configuration.
- `stall` = `hz(id_src1)` or (`id_two_src` and `hz(id_src2)`).
- WB-stage writes never cause a stall; the register file writes on the falling edge.
- Priority when not frozen: `branch_taken` > `stall` > normal.
  - Branch: all `ld`=1, `if_id_flush`=1, `id_ex_flush`=1. Any concurrent stall is discarded.
  - Stall: `pc_ld`=0, `if_id_ld`=0, `id_ex_ld`=1, `id_ex_flush`=1, `ex_mem_ld`=1, `mem_wb_ld`=1.
  - Normal: all `ld`=1, both flushes 0.
- `status_ld` = `ex_s_upd` and not `freeze`.
- A `branch_taken` raised during a freeze stays held in EX and is acted on in the first unfrozen cycle.

## Timing
- FSM state and `cnt` are registered. All other outputs are combinational from inputs and state, with zero latency.
- Freeze length per access: MEM_WAIT+1 cycles (the IDLE request cycle plus MEM_WAIT WAIT cycles), followed by one DONE advance cycle.
- Back-to-back memory instructions: DONE, then IDLE, then a new freeze begins on the next cycle. There is no gap beyond DONE.
- Reset: FSM goes to IDLE and `cnt` to 0. While `rst`=1, all outputs are 0, including `fwd_sel`.
- A reset asserted mid-WAIT aborts the access immediately. After release the FSM starts in IDLE.
- Matching a destination of register 0 is treated as a normal register; no hardwired-zero exemption.

## Configuration
- Macro: `PIPELINE_FORWARDING_EN`.
- Defined:
  - `hz(s)` = `ex_mem_rd` and `ex_wb_en` and `ex_dest`==`s` (load-use only).
  - `fwd_selN` = 01 if `mem_wb_en` and `mem_dest`==`ex_srcN`; else 10 if `wb_wb_en` and `wb_dest`==`ex_srcN`; else 00. MEM has priority.
- Undefined:
  - Full hazard comparison as described in Operation.
  - `fwd_sel1` = `fwd_sel2` = 00 constantly.
  - `ex_src1`, `ex_src2`, `wb_dest`, `wb_wb_en` are unused.

## Test plan
- Reset release with all inputs 0 → all `ld`=1, both flushes 0, `freeze`=0, `fwd_sel`=00.
- `mem_req`=1 held with MEM_WAIT=4 → `freeze`=1 for exactly 5 cycles, then 1 cycle with all `ld`=1, then a new 5-cycle freeze.
- Without macro: `id_src1`=3, `ex_dest`=3, `ex_wb_en`=1 → `pc_ld`=0, `if_id_ld`=0, `id_ex_ld`=1, `id_ex_flush`=1.
  - Repeat with `id_two_src`=0 and the match on `id_src2` only → no stall.
- `branch_taken`=1 together with the stall condition above → all `ld`=1, `if_id_flush`=1, `id_ex_flush`=1.
  - Repeat with `branch_taken`=1 during a freeze → all 0 until DONE.
- With macro: `ex_src1`=5, `mem_dest`=5, `mem_wb_en`=1, `wb_dest`=5, `wb_wb_en`=1 → `fwd_sel1`=01.
  - Same with `ex_mem_rd`=1 and `ex_dest`==`id_src1` → load-use stall.
- `rst` pulsed on the second WAIT cycle → `freeze` drops at once. After release, `mem_req`=0 gives `freeze`=0 and all `ld`=1.

Source files
------------

// File: rtl/pipeline_hazard_ctrl_if.sv
// ---------------------------------------------------------------------------
// pipeline_hazard_ctrl_if
// Purpose : bundles the pipeline-status inputs and the load/flush/forward
//           controls exchanged between the five-stage datapath and the
//           hazard controller.
// Modports: master - datapath side (drives stage status, receives controls)
//           slave  - hazard controller side
// Signals :
//   id_src1/id_src2/id_two_src       ID-stage source registers
//   ex_dest/ex_wb_en/ex_mem_rd       EX-stage destination, writeback, load
//   mem_dest/mem_wb_en               MEM-stage destination, writeback
//   wb_dest/wb_wb_en                 WB-stage destination, writeback
//   ex_src1/ex_src2                  EX-stage sources (forwarding only)
//   mem_req                          MEM instruction accesses data memory
//   branch_taken/ex_s_upd            EX branch resolution, flag update
//   *_ld, *_flush, status_ld         register load / flush controls
//   fwd_sel1/fwd_sel2                EX operand select (00 RF, 01 MEM, 10 WB)
//   freeze                           memory freeze active
// ---------------------------------------------------------------------------
interface pipeline_hazard_ctrl_if #(
   parameter int unsigned REG_AW = 4
) ();
   logic [REG_AW-1:0] id_src1;
   logic [REG_AW-1:0] id_src2;
   logic              id_two_src;
   logic [REG_AW-1:0] ex_dest;
   logic              ex_wb_en;
   logic              ex_mem_rd;
   logic [REG_AW-1:0] mem_dest;
   logic              mem_wb_en;
   logic [REG_AW-1:0] wb_dest;
   logic              wb_wb_en;
   logic [REG_AW-1:0] ex_src1;
   logic [REG_AW-1:0] ex_src2;
   logic              mem_req;
   logic              branch_taken;
   logic              ex_s_upd;

   logic              pc_ld;
   logic              if_id_ld;
   logic              id_ex_ld;
   logic              ex_mem_ld;
   logic              mem_wb_ld;
   logic              if_id_flush;
   logic              id_ex_flush;
   logic              status_ld;
   logic [1:0]        fwd_sel1;
   logic [1:0]        fwd_sel2;
   logic              freeze;

   modport master (
      output id_src1, id_src2, id_two_src, ex_dest, ex_wb_en, ex_mem_rd,
             mem_dest, mem_wb_en, wb_dest, wb_wb_en, ex_src1, ex_src2,
             mem_req, branch_taken, ex_s_upd,
      input  pc_ld, if_id_ld, id_ex_ld, ex_mem_ld, mem_wb_ld,
             if_id_flush, id_ex_flush, status_ld, fwd_sel1, fwd_sel2, freeze
   );

   modport slave (
      input  id_src1, id_src2, id_two_src, ex_dest, ex_wb_en, ex_mem_rd,
             mem_dest, mem_wb_en, wb_dest, wb_wb_en, ex_src1, ex_src2,
             mem_req, branch_taken, ex_s_upd,
      output pc_ld, if_id_ld, id_ex_ld, ex_mem_ld, mem_wb_ld,
             if_id_flush, id_ex_flush, status_ld, fwd_sel1, fwd_sel2, freeze
   );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipeline_hazard_ctrl
// Purpose : central stall/flush controller for the IF/ID/EX/MEM/WB pipeline.
//           Inserts bubbles on data hazards, squashes wrong-path instructions
//           on taken branches and freezes the pipeline during multi-cycle
//           data-memory accesses.
// Ports   : clk   - clock
//           rst   - asynchronous, active-high reset
//           hz_if - pipeline_hazard_ctrl_if.slave (stage status in,
//                   load/flush/forward controls out, all combinational)
// Config  : define PIPELINE_FORWARDING_EN to enable EX operand forwarding;
//           hazards then reduce to load-use only. Default build has no
//           forwarding and fwd_sel1/fwd_sel2 stay 00.
// ---------------------------------------------------------------------------
module pipeline_hazard_ctrl #(
   parameter int unsigned MEM_WAIT = 4,
   parameter int unsigned REG_AW   = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   pipeline_hazard_ctrl_if.slave hz_if
);

   localparam int unsigned CNT_W = 4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   state_e           state_q;
   logic [CNT_W-1:0] cnt_q;
   logic             freeze_c;
   logic             hz_src1_c;
   logic             hz_src2_c;
   logic             stall_c;
   logic [1:0]       fwd1_c;
   logic [1:0]       fwd2_c;

   function automatic logic hit(input logic en, input logic [REG_AW-1:0] dest,
                                input logic [REG_AW-1:0] src);
      return en & (dest == src);
   endfunction

   // Memory-access FSM; DONE gives one unfrozen advance cycle between accesses
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (hz_if.mem_req) begin
                  state_q <= ST_WAIT;
                  cnt_q   <= CNT_W'(MEM_WAIT - 1);
               end
            end
            ST_WAIT: begin
               if (cnt_q == '0) state_q <= ST_DONE;
               else             cnt_q   <= cnt_q - CNT_W'(1);
            end
            ST_DONE: state_q <= ST_IDLE;
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   // Freeze starts in the request cycle itself, not one cycle later
   assign freeze_c = (state_q == ST_WAIT) | ((state_q == ST_IDLE) & hz_if.mem_req);

`ifdef PIPELINE_FORWARDING_EN
   // With forwarding only a load in EX cannot be bypassed in time
   assign hz_src1_c = hz_if.ex_mem_rd & hit(hz_if.ex_wb_en, hz_if.ex_dest, hz_if.id_src1);
   assign hz_src2_c = hz_if.ex_mem_rd & hit(hz_if.ex_wb_en, hz_if.ex_dest, hz_if.id_src2);

   // MEM result is younger than WB, so it wins
   always_comb begin
      fwd1_c = 2'b00;
      fwd2_c = 2'b00;
      if (hit(hz_if.mem_wb_en, hz_if.mem_dest, hz_if.ex_src1))     fwd1_c = 2'b01;
      else if (hit(hz_if.wb_wb_en, hz_if.wb_dest, hz_if.ex_src1))  fwd1_c = 2'b10;
      if (hit(hz_if.mem_wb_en, hz_if.mem_dest, hz_if.ex_src2))     fwd2_c = 2'b01;
      else if (hit(hz_if.wb_wb_en, hz_if.wb_dest, hz_if.ex_src2))  fwd2_c = 2'b10;
   end
`else
   // WB is excluded: the register file writes on the falling edge
   assign hz_src1_c = hit(hz_if.ex_wb_en, hz_if.ex_dest, hz_if.id_src1) |
                      hit(hz_if.mem_wb_en, hz_if.mem_dest, hz_if.id_src1);
   assign hz_src2_c = hit(hz_if.ex_wb_en, hz_if.ex_dest, hz_if.id_src2) |
                      hit(hz_if.mem_wb_en, hz_if.mem_dest, hz_if.id_src2);
   assign fwd1_c    = 2'b00;
   assign fwd2_c    = 2'b00;

   logic fwd_unused;
   assign fwd_unused = ^{hz_if.ex_src1, hz_if.ex_src2, hz_if.wb_dest,
                         hz_if.wb_wb_en, hz_if.ex_mem_rd};
`endif

   assign stall_c = hz_src1_c | (hz_if.id_two_src & hz_src2_c);

   // Control outputs: reset > freeze > branch > stall > normal
   always_comb begin
      hz_if.pc_ld       = 1'b0;
      hz_if.if_id_ld    = 1'b0;
      hz_if.id_ex_ld    = 1'b0;
      hz_if.ex_mem_ld   = 1'b0;
      hz_if.mem_wb_ld   = 1'b0;
      hz_if.if_id_flush = 1'b0;
      hz_if.id_ex_flush = 1'b0;
      hz_if.status_ld   = 1'b0;
      hz_if.fwd_sel1    = 2'b00;
      hz_if.fwd_sel2    = 2'b00;
      hz_if.freeze      = 1'b0;
      if (!rst) begin
         hz_if.freeze   = freeze_c;
         hz_if.fwd_sel1 = fwd1_c;
         hz_if.fwd_sel2 = fwd2_c;
         if (!freeze_c) begin
            hz_if.status_ld = hz_if.ex_s_upd;
            hz_if.id_ex_ld  = 1'b1;
            hz_if.ex_mem_ld = 1'b1;
            hz_if.mem_wb_ld = 1'b1;
            if (hz_if.branch_taken) begin
               hz_if.pc_ld       = 1'b1;
               hz_if.if_id_ld    = 1'b1;
               hz_if.if_id_flush = 1'b1;
               hz_if.id_ex_flush = 1'b1;
            end else if (stall_c) begin
               // Hold PC and IF/ID, push a bubble into ID/EX
               hz_if.id_ex_flush = 1'b1;
            end else begin
               hz_if.pc_ld    = 1'b1;
               hz_if.if_id_ld = 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
module tb_pipeline_hazard_ctrl;

   localparam int unsigned MEM_WAIT = 4;
   localparam int unsigned REG_AW   = 4;

   // Observed vector: {pc,if_id,id_ex,ex_mem,mem_wb ld, if_id/id_ex flush,
   //                   status_ld, fwd_sel1, fwd_sel2, freeze}
   localparam logic [12:0] EXP_RST  = 13'b00000_00_0_00_00_0;
   localparam logic [12:0] EXP_NORM = 13'b11111_00_0_00_00_0;
   localparam logic [12:0] EXP_STL  = 13'b00111_01_0_00_00_0;
   localparam logic [12:0] EXP_BR   = 13'b11111_11_0_00_00_0;
   localparam logic [12:0] EXP_FRZ  = 13'b00000_00_0_00_00_1;
   localparam logic [12:0] ST_BIT   = 13'b00000_00_1_00_00_0;

`ifdef PIPELINE_FORWARDING_EN
   localparam bit FWD = 1'b1;
`else
   localparam bit FWD = 1'b0;
`endif

   typedef struct {
      logic [3:0]  s1, s2;
      logic        two;
      logic [3:0]  exd;
      logic        exwb, exrd;
      logic [3:0]  md;
      logic        mwb;
      logic [3:0]  wd;
      logic        wwb;
      logic        br, su;
      logic [12:0] exp;
   } vec_t;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   pipeline_hazard_ctrl_if #(.REG_AW(REG_AW)) bus ();

   pipeline_hazard_ctrl #(.MEM_WAIT(MEM_WAIT), .REG_AW(REG_AW)) dut (
      .clk   (clk),
      .rst   (rst),
      .hz_if (bus)
   );

   logic [12:0] exp_q[$];
   int checks = 0;
   int errors = 0;

   function automatic logic [12:0] observe();
      return {bus.pc_ld, bus.if_id_ld, bus.id_ex_ld, bus.ex_mem_ld, bus.mem_wb_ld,
              bus.if_id_flush, bus.id_ex_flush, bus.status_ld,
              bus.fwd_sel1, bus.fwd_sel2, bus.freeze};
   endfunction

   task automatic clear_inputs();
      bus.id_src1 = '0; bus.id_src2 = '0; bus.id_two_src = 1'b0;
      bus.ex_dest = '0; bus.ex_wb_en = 1'b0; bus.ex_mem_rd = 1'b0;
      bus.mem_dest = '0; bus.mem_wb_en = 1'b0;
      bus.wb_dest = '0; bus.wb_wb_en = 1'b0;
      bus.ex_src1 = '0; bus.ex_src2 = '0;
      bus.mem_req = 1'b0; bus.branch_taken = 1'b0; bus.ex_s_upd = 1'b0;
   endtask

   task automatic apply_vec(input vec_t v);
      clear_inputs();
      bus.id_src1 = v.s1; bus.id_src2 = v.s2; bus.id_two_src = v.two;
      bus.ex_dest = v.exd; bus.ex_wb_en = v.exwb; bus.ex_mem_rd = v.exrd;
      bus.mem_dest = v.md; bus.mem_wb_en = v.mwb;
      bus.wb_dest = v.wd; bus.wb_wb_en = v.wwb;
      bus.branch_taken = v.br; bus.ex_s_upd = v.su;
   endtask

   task automatic test_reset();
      logic [12:0] got, exp;
      rst = 1'b1;
      clear_inputs();
      bus.mem_req = 1'b1; bus.ex_src1 = 4'd5; bus.mem_dest = 4'd5; bus.mem_wb_en = 1'b1;
      bus.ex_s_upd = 1'b1;
      exp_q.push_back(EXP_RST);
      @(negedge clk);
      got = observe(); exp = exp_q.pop_front(); checks++;
      if (got !== exp) begin errors++; $display("FAIL reset_hold got=%b exp=%b", got, exp); end
      @(posedge clk); #1;
      rst = 1'b0;
      clear_inputs();
      exp_q.push_back(EXP_NORM);
      @(negedge clk);
      got = observe(); exp = exp_q.pop_front(); checks++;
      if (got !== exp) begin errors++; $display("FAIL reset_release got=%b exp=%b", got, exp); end
      @(posedge clk); #1;
   endtask

   task automatic test_stall();
      vec_t tbl[9];
      logic [12:0] got, exp;
      tbl = '{
         '{4'd3, 4'd0, 1'b0, 4'd3, 1'b1, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, FWD ? EXP_NORM : EXP_STL},
         '{4'd0, 4'd3, 1'b0, 4'd3, 1'b1, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, EXP_NORM},
         '{4'd0, 4'd3, 1'b1, 4'd3, 1'b1, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, FWD ? EXP_NORM : EXP_STL},
         '{4'd7, 4'd0, 1'b0, 4'd1, 1'b0, 1'b0, 4'd7, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0, FWD ? EXP_NORM : EXP_STL},
         '{4'd9, 4'd0, 1'b0, 4'd1, 1'b0, 1'b0, 4'd1, 1'b0, 4'd9, 1'b1, 1'b0, 1'b0, EXP_NORM},
         '{4'd0, 4'd2, 1'b0, 4'd0, 1'b1, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, EXP_STL},
         '{4'd3, 4'd0, 1'b0, 4'd3, 1'b0, 1'b1, 4'd3, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, EXP_NORM},
         '{4'd4, 4'd0, 1'b0, 4'd4, 1'b1, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, EXP_STL},
         '{4'd1, 4'd5, 1'b1, 4'd5, 1'b1, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, EXP_STL}
      };
      for (int i = 0; i < 9; i++) begin
         apply_vec(tbl[i]);
         exp_q.push_back(tbl[i].exp);
         @(negedge clk);
         got = observe(); exp = exp_q.pop_front(); checks++;
         if (got !== exp) begin errors++; $display("FAIL stall_case%0d got=%b exp=%b", i, got, exp); end
         @(posedge clk); #1;
      end
      clear_inputs();
   endtask

   task automatic test_branch();
      vec_t tbl[4];
      logic [12:0] got, exp;
      tbl = '{
         '{4'd3, 4'd0, 1'b0, 4'd3, 1'b1, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0, EXP_BR},
         '{4'd0, 4'd0, 1'b0, 4'd1, 1'b0, 1'b0, 4'd1, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0, EXP_BR},
         '{4'd0, 4'd0, 1'b0, 4'd1, 1'b0, 1'b0, 4'd1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, EXP_NORM | ST_BIT},
         '{4'd6, 4'd0, 1'b0, 4'd6, 1'b1, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, EXP_STL | ST_BIT}
      };
      for (int i = 0; i < 4; i++) begin
         apply_vec(tbl[i]);
         exp_q.push_back(tbl[i].exp);
         @(negedge clk);
         got = observe(); exp = exp_q.pop_front(); checks++;
         if (got !== exp) begin errors++; $display("FAIL branch_case%0d got=%b exp=%b", i, got, exp); end
         @(posedge clk); #1;
      end
      clear_inputs();
   endtask

   task automatic test_freeze();
      logic [12:0] got, exp;
      int n = 2 * (int'(MEM_WAIT) + 2);
      clear_inputs();
      bus.mem_req = 1'b1;
      bus.ex_s_upd = 1'b1;
      for (int k = 0; k < 2; k++) begin
         for (int j = 0; j <= int'(MEM_WAIT); j++) exp_q.push_back(EXP_FRZ);
         exp_q.push_back(EXP_NORM | ST_BIT);
      end
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         got = observe(); exp = exp_q.pop_front(); checks++;
         if (got !== exp) begin errors++; $display("FAIL freeze_cycle%0d got=%b exp=%b", i, got, exp); end
         @(posedge clk); #1;
      end
      clear_inputs();
      exp_q.push_back(EXP_NORM);
      @(negedge clk);
      got = observe(); exp = exp_q.pop_front(); checks++;
      if (got !== exp) begin errors++; $display("FAIL freeze_idle got=%b exp=%b", got, exp); end
      @(posedge clk); #1;
   endtask

   task automatic test_branch_freeze();
      logic [12:0] got, exp;
      clear_inputs();
      bus.mem_req = 1'b1;
      bus.branch_taken = 1'b1;
      for (int j = 0; j <= int'(MEM_WAIT); j++) exp_q.push_back(EXP_FRZ);
      exp_q.push_back(EXP_BR);
      for (int i = 0; i <= int'(MEM_WAIT) + 1; i++) begin
         @(negedge clk);
         got = observe(); exp = exp_q.pop_front(); checks++;
         if (got !== exp) begin errors++; $display("FAIL branch_freeze_cycle%0d got=%b exp=%b", i, got, exp); end
         @(posedge clk); #1;
      end
      clear_inputs();
      exp_q.push_back(EXP_NORM);
      @(negedge clk);
      got = observe(); exp = exp_q.pop_front(); checks++;
      if (got !== exp) begin errors++; $display("FAIL branch_freeze_after got=%b exp=%b", got, exp); end
      @(posedge clk); #1;
   endtask

   task automatic test_reset_mid_wait();
      logic [12:0] got, exp;
      clear_inputs();
      bus.mem_req = 1'b1;
      exp_q.push_back(EXP_FRZ);
      exp_q.push_back(EXP_FRZ);
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         got = observe(); exp = exp_q.pop_front(); checks++;
         if (got !== exp) begin errors++; $display("FAIL rst_wait_pre%0d got=%b exp=%b", i, got, exp); end
         @(posedge clk); #1;
      end
      rst = 1'b1;
      exp_q.push_back(EXP_RST);
      #1;
      got = observe(); exp = exp_q.pop_front(); checks++;
      if (got !== exp) begin errors++; $display("FAIL rst_wait_abort got=%b exp=%b", got, exp); end
      @(posedge clk); #1;
      rst = 1'b0;
      bus.mem_req = 1'b0;
      exp_q.push_back(EXP_NORM);
      exp_q.push_back(EXP_NORM);
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         got = observe(); exp = exp_q.pop_front(); checks++;
         if (got !== exp) begin errors++; $display("FAIL rst_wait_post%0d got=%b exp=%b", i, got, exp); end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_forwarding();
      logic [12:0] got, exp;
      logic [12:0] exps[4];
      // fwd_sel1 at bits [4:3], fwd_sel2 at bits [2:1]
      if (FWD) exps = '{EXP_NORM | 13'h00A, EXP_NORM | 13'h014, EXP_NORM | 13'h010, EXP_STL};
      else     exps = '{EXP_NORM,           EXP_NORM,           EXP_NORM,           EXP_STL};
      clear_inputs();
      bus.ex_src1 = 4'd5; bus.ex_src2 = 4'd5;
      bus.mem_dest = 4'd5; bus.mem_wb_en = 1'b1;
      bus.wb_dest = 4'd5; bus.wb_wb_en = 1'b1;
      for (int i = 0; i < 4; i++) begin
         case (i)
            1: bus.mem_wb_en = 1'b0;
            2: bus.ex_src2 = 4'd6;
            3: begin
               bus.wb_wb_en = 1'b0;
               bus.id_src1 = 4'd2; bus.ex_dest = 4'd2;
               bus.ex_wb_en = 1'b1; bus.ex_mem_rd = 1'b1;
            end
            default: ;
         endcase
         exp_q.push_back(exps[i]);
         @(negedge clk);
         got = observe(); exp = exp_q.pop_front(); checks++;
         if (got !== exp) begin errors++; $display("FAIL fwd_case%0d got=%b exp=%b", i, got, exp); end
         @(posedge clk); #1;
      end
      clear_inputs();
   endtask

   initial begin
      rst = 1'b1;
      clear_inputs();
      test_reset();
      test_stall();
      test_branch();
      test_freeze();
      test_branch_freeze();
      test_reset_mid_wait();
      test_forwarding();
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain left=%0d required=0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
